// File: rtl/rom_arbiter.sv
// Two-port round-robin read arbiter in front of a synchronous single-port ROM.
// Each granted access walks IDLE -> ADDR -> DATA -> ACK, one read per four cycles.
//
// state | meaning
// IDLE  | waiting for a request; winner's address and id latched on grant
// ADDR  | address presented to ROM with chip enable
// DATA  | ROM output enabled; read word captured at end of cycle
// ACK   | one-cycle acknowledge to the granted port
module rom_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_data,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_data,
  output logic [ADDR_W-1:0] rom_a,
  output logic              rom_ce,
  output logic              rom_oe,
  input  logic [DATA_W-1:0] rom_d
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, ACK} state_t;

  state_t state, state_nxt;
  logic   grant_dbg;
  logic   last_dbg;
  logic   win_dbg;
  logic   grant_now;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    // On a tie the port that did not win last time takes the grant.
    win_dbg   = dbg_req && (!cpu_req || !last_dbg);
    grant_now = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          grant_now = 1'b1;
          state_nxt = ADDR;
        end
      end
      ADDR:    state_nxt = DATA;
      DATA:    state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_a     <= '0;
      grant_dbg <= 1'b0;
      last_dbg  <= 1'b1;
      cpu_data  <= '0;
      dbg_data  <= '0;
    end else begin
      if (grant_now) begin
        grant_dbg <= win_dbg;
        last_dbg  <= win_dbg;
        rom_a     <= win_dbg ? dbg_addr : cpu_addr;
      end
      if (state == DATA) begin
        if (grant_dbg) dbg_data <= rom_d;
        else           cpu_data <= rom_d;
      end
    end
  end

  assign rom_ce  = (state == ADDR) || (state == DATA);
  assign rom_oe  = (state == DATA);
  assign cpu_ack = (state == ACK) && !grant_dbg;
  assign dbg_ack = (state == ACK) && grant_dbg;

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: a behavioural synchronous ROM feeds the DUT,
// expected acks (port, data, cycle) are queued at stimulus time and popped on each ack.
module tb_rom_arbiter;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cpu_req = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_data;
  logic              dbg_req = 1'b0;
  logic [ADDR_W-1:0] dbg_addr = '0;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_data;
  logic [ADDR_W-1:0] rom_a;
  logic              rom_ce;
  logic              rom_oe;
  logic [DATA_W-1:0] rom_d = '0;

  rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .cpu_data(cpu_data),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_data(dbg_data),
    .rom_a(rom_a), .rom_ce(rom_ce), .rom_oe(rom_oe), .rom_d(rom_d)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) if (rom_ce) rom_d <= mem[rom_a];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit              dbg;
    logic [DATA_W-1:0] data;
    int              cyc;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (cpu_ack || dbg_ack)) begin
      exp_t e;
      if (cpu_ack && dbg_ack) chk("dual_ack", 1, 0);
      if (sb.size() == 0) begin
        chk("unexpected_ack", {30'd0, dbg_ack, cpu_ack}, 0);
      end else begin
        e = sb.pop_front();
        chk("ack_port", {31'd0, dbg_ack}, {31'd0, e.dbg});
        chk("ack_data", dbg_ack ? dbg_data : cpu_data, e.data);
        chk("ack_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic push(input bit dbg, input logic [ADDR_W-1:0] a, input int at);
    exp_t e;
    e.dbg = dbg; e.data = mem[a]; e.cyc = at;
    sb.push_back(e);
  endtask

  // Wait for the port's ack, then drop its request before the ACK cycle ends.
  task automatic wait_ack(input bit dbg);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (dbg ? dbg_ack : cpu_ack) begin
        seen = 1;
        if (dbg) dbg_req = 1'b0;
        else     cpu_req = 1'b0;
      end
    end
    if (!seen) chk(dbg ? "dbg_ack_timeout" : "cpu_ack_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'($urandom);
    mem[13'h0000] = 16'h4E71;
    mem[13'h0001] = 16'h1111;
    mem[13'h0010] = 16'h1010;
    mem[13'h0100] = 16'hA100;
    mem[13'h0200] = 16'hA200;
    mem[13'h1FFF] = 16'hBEEF;
    mem[13'h0055] = 16'h5555;

    repeat (3) @(negedge clk);
    chk("rst_cpu_ack", {31'd0, cpu_ack}, 0);
    chk("rst_dbg_ack", {31'd0, dbg_ack}, 0);
    chk("rst_rom_ce", {31'd0, rom_ce}, 0);
    chk("rst_rom_oe", {31'd0, rom_oe}, 0);
    chk("rst_rom_a", rom_a, 0);
    chk("rst_cpu_data", cpu_data, 0);
    chk("rst_dbg_data", dbg_data, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single CPU read, 3-cycle latency.
    cpu_addr = 13'h0000; cpu_req = 1'b1;
    push(0, 13'h0000, cyc + 3);
    wait_ack(0);
    chk("single_dbg_data", dbg_data, 0);

    // Tie right after reset: CPU first, debug four cycles later.
    do_reset();
    cpu_addr = 13'h0010; dbg_addr = 13'h1FFF;
    cpu_req = 1'b1; dbg_req = 1'b1;
    push(0, 13'h0010, cyc + 3);
    push(1, 13'h1FFF, cyc + 7);
    fork
      wait_ack(0);
      wait_ack(1);
    join

    // Both held for 32 cycles: 8 alternating acks, 4 cycles apart.
    @(negedge clk);
    cpu_addr = 13'h0123; dbg_addr = 13'h0ABC;
    cpu_req = 1'b1; dbg_req = 1'b1;
    for (int k = 0; k < 8; k++)
      push(k[0], k[0] ? 13'h0ABC : 13'h0123, cyc + 3 + 4 * k);
    repeat (31) @(negedge clk);
    cpu_req = 1'b0; dbg_req = 1'b0;
    @(negedge clk);
    chk("rr_drained", sb.size(), 0);

    // Debug read then CPU read; debug data register must be left alone.
    dbg_addr = 13'h1FFF; dbg_req = 1'b1;
    push(1, 13'h1FFF, cyc + 3);
    wait_ack(1);
    @(negedge clk);
    cpu_addr = 13'h0001; cpu_req = 1'b1;
    push(0, 13'h0001, cyc + 3);
    wait_ack(0);
    chk("iso_dbg_data", dbg_data, 16'hBEEF);
    chk("iso_cpu_data", cpu_data, 16'h1111);

    // Address change after grant must not reach the ROM.
    @(negedge clk);
    cpu_addr = 13'h0100; cpu_req = 1'b1;
    push(0, 13'h0100, cyc + 3);
    @(negedge clk);
    cpu_addr = 13'h0200;
    chk("hold_rom_a_addr", rom_a, 13'h0100);
    @(negedge clk);
    chk("hold_rom_a_data", rom_a, 13'h0100);
    chk("data_rom_oe", {31'd0, rom_oe}, 1);
    chk("data_rom_ce", {31'd0, rom_ce}, 1);
    wait_ack(0);

    // Reset during DATA aborts the access; debug request held through reset.
    @(negedge clk);
    cpu_addr = 13'h0055; cpu_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_in_data", {31'd0, rom_oe}, 1);
    reset = 1'b1; cpu_req = 1'b0;
    dbg_addr = 13'h1ABC; dbg_req = 1'b1;
    @(negedge clk);
    chk("abort_cpu_ack", {31'd0, cpu_ack}, 0);
    chk("abort_rom_ce", {31'd0, rom_ce}, 0);
    chk("abort_cpu_data", cpu_data, 0);
    chk("abort_dbg_data", dbg_data, 0);
    reset = 1'b0;
    push(1, 13'h1ABC, cyc + 3);
    wait_ack(1);
    repeat (3) @(negedge clk);

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter ADDR_W, default 13: ROM word-address width.
REQ-002 Parameter DATA_W, default 16: ROM word width.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 cpu_req  input  1  CPU read request; level, held until cpu_ack seen.
REQ-006 cpu_addr  input  ADDR_W  CPU word address, stable while cpu_req high.
REQ-007 cpu_ack  output  1  one-cycle pulse; cpu_data valid in the same cycle.
REQ-008 cpu_data  output  DATA_W  registered read data for CPU.
REQ-009 dbg_req  input  1  debug/loader read request; same rules as cpu_req.
REQ-010 dbg_addr  input  ADDR_W  debug word address.
REQ-011 dbg_ack  output  1  one-cycle pulse; dbg_data valid in the same cycle.
REQ-012 dbg_data  output  DATA_W  registered read data for debug port.
REQ-013 rom_a  output  ADDR_W  address to synchronous ROM (registered read, 1-cycle latency).
REQ-014 rom_ce  output  1  ROM chip enable.
REQ-015 rom_oe  output  1  ROM output enable.
REQ-016 rom_d  input  DATA_W  ROM read data, valid one cycle after rom_a/rom_ce presented.

Function
REQ-017 The block SHALL implement states IDLE, ADDR, DATA, ACK; all outputs registered or decoded from state and registers only.
REQ-018 IDLE: no request -> stay IDLE; any request -> latch winner's address and grant id, go ADDR.
REQ-019 Both requests in same IDLE cycle -> round-robin: grant the requester not granted last; last_grant reset value = dbg, so CPU wins first tie.
REQ-020 Single request -> granted regardless of last_grant; last_grant updates on every grant.
REQ-021 ADDR: rom_a = latched address, rom_ce = 1; unconditionally go DATA.
REQ-022 DATA: rom_ce = 1, rom_oe = 1, rom_a held; at end of cycle rom_d captured into granted port's data register only; go ACK.
REQ-023 ACK: granted port's ack = 1 for exactly this cycle; other port's ack = 0; go IDLE; requests ignored in ACK.
REQ-024 Outside ADDR/DATA: rom_ce = 0, rom_oe = 0, rom_a holds last value.
REQ-025 Latency: request high in IDLE cycle N -> ack high in cycle N+3; max throughput one read per 4 cycles.
REQ-026 Non-granted port's data register SHALL be unchanged by another port's read.
REQ-027 Request dropped before ack (protocol violation) SHALL NOT abort the sequence; ack still issued.
REQ-028 Address changes on the inputs after grant SHALL NOT affect rom_a for the current access.
REQ-029 Starvation bound: with both requests continuously pending, each port acked at least once per 8 cycles.
REQ-030 Address wrap: all 2^ADDR_W addresses passed unmodified; no arithmetic on addresses.

Reset
REQ-031 Reset SHALL force state IDLE, cpu_ack = dbg_ack = 0, rom_ce = rom_oe = 0, rom_a = 0, cpu_data = dbg_data = 0, last_grant = dbg.
REQ-032 Reset asserted in any state, including mid-access, SHALL take effect at that edge; no ack issued for the aborted access.
REQ-033 Reset SHALL dominate requests sampled on the same edge; first grant possible in first cycle after reset deasserts.

Verification
REQ-034 Reset, then cpu_req=1, cpu_addr=0x0000, ROM word 0x4E71 -> cpu_ack high exactly 3 cycles later, cpu_data=0x4E71, dbg_ack stays 0.
REQ-035 cpu_req and dbg_req rise together after reset, addrs 0x0010/0x1FFF -> CPU acked first (cycle +3) with ROM[0x0010], debug acked at cycle +7 with ROM[0x1FFF].
REQ-036 Both requests held continuously (re-asserted after each ack) for 32 cycles -> acks alternate CPU, dbg, CPU, ..., 8 total, gap 4 cycles.
REQ-037 dbg read of 0x1FFF completes (dbg_data=ROM[0x1FFF]), then CPU read of 0x0001 -> dbg_data unchanged, cpu_data=ROM[0x0001].
REQ-038 Reset asserted during DATA state of a CPU read -> next cycle IDLE, rom_ce=0, no cpu_ack, cpu_data=0.
REQ-039 cpu_addr changed from 0x0100 to 0x0200 one cycle after grant -> rom_a stays 0x0100, cpu_data=ROM[0x0100].
